sync_fifo_ctrl: RTL and testbench

Pointer, flag and arbitration controller for the synchronous FIFO. It is the initiator that drives the FIFO storage SRAM port: write pointer, read pointer, write enable and read enable. Upstream and downstream agents talk to it through req/ack handshakes. The SRAM performs nothing when write and read enables are asserted together, so this block serialises access and grants at most one operation per cycle, with fair arbitration under contention.

---
 rtl/sync_fifo_ctrl_pkg.sv | 16 +
 rtl/fifo_arb.sv | 53 +++++
 rtl/sync_fifo_ctrl.sv | 100 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared FIFO definitions: default geometry and arbitration priority encoding.
// The controller, the SRAM wrapper and the top-level FIFO all import this package
// so that they agree on sizes and on what each priority value means.
package sync_fifo_ctrl_pkg;

  localparam int unsigned FIFO_PTR_DEF   = 4;
  localparam int unsigned FIFO_WIDTH_DEF = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 16;

  // Which requester wins the next contended cycle.
  typedef enum logic {
    PRIO_PUSH = 1'b0,
    PRIO_POP  = 1'b1
  } prio_e;

endpackage

// File: rtl/fifo_arb.sv
// Two-requester round-robin arbiter. It grants at most one requester per cycle.
// Under contention the side named by the priority register wins, and the priority
// then flips to the other side. An uncontended grant leaves the priority unchanged.
// Grants are combinational from the registered priority and are held low in reset.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_a, req_b      eligible requests (a = push side, b = pop side)
//   grant_a, grant_b  one-hot-or-zero grants
module fifo_arb
  import sync_fifo_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  prio_e prio_q;
  prio_e prio_d;

  // Priority state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= PRIO_PUSH;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Grant selection and next priority.
  always_comb begin
    prio_d  = prio_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (req_a && req_b) begin
        if (prio_q == PRIO_PUSH) begin
          grant_a = 1'b1;
          prio_d  = PRIO_POP;
        end else begin
          grant_b = 1'b1;
          prio_d  = PRIO_PUSH;
        end
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer, flag and arbitration controller for the synchronous FIFO.
// It drives the single-port-style FIFO SRAM. Only one of write or read is enabled
// per cycle, because the SRAM does nothing when both enables are high.
// Ports:
//   fifo_clk, fifo_rst             clock, asynchronous active-high reset
//   push_req/push_data/push_ack    producer handshake (request held until ack)
//   pop_req/pop_ack                consumer handshake (request held until ack)
//   pop_data/pop_valid             read data, valid the cycle after pop_ack
//   fifo_full/empty/afull/aempty   occupancy flags from the registered count
//   fifo_count                     occupancy, 0..FIFO_DEPTH
//   sram_wrdata/sram_rddata        SRAM data in/out
//   wr_ptr/rd_ptr                  SRAM write/read addresses
//   sram_wren/sram_rden            SRAM enables (mutually exclusive)
//   sram_rstb                      SRAM enable, low in reset, high from first edge after
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_PTR   = FIFO_PTR_DEF,
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned AFULL_TH   = 12,
  parameter int unsigned AEMPTY_TH  = 4
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst,
  input  logic                  push_req,
  input  logic [FIFO_WIDTH-1:0] push_data,
  output logic                  push_ack,
  input  logic                  pop_req,
  output logic                  pop_ack,
  output logic [FIFO_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_afull,
  output logic                  fifo_aempty,
  output logic [FIFO_PTR:0]     fifo_count,
  output logic [FIFO_WIDTH-1:0] sram_wrdata,
  input  logic [FIFO_WIDTH-1:0] sram_rddata,
  output logic [FIFO_PTR-1:0]   wr_ptr,
  output logic [FIFO_PTR-1:0]   rd_ptr,
  output logic                  sram_wren,
  output logic                  sram_rden,
  output logic                  sram_rstb
);

  localparam int unsigned CNT_W = FIFO_PTR + 1;

  logic push_elig;
  logic pop_elig;
  logic push_gnt;
  logic pop_gnt;

  assign push_elig = push_req & ~fifo_full;
  assign pop_elig  = pop_req & ~fifo_empty;

  fifo_arb u_arb (
    .clk     (fifo_clk),
    .rst     (fifo_rst),
    .req_a   (push_elig),
    .req_b   (pop_elig),
    .grant_a (push_gnt),
    .grant_b (pop_gnt)
  );

  assign push_ack    = push_gnt;
  assign sram_wren   = push_gnt;
  assign pop_ack     = pop_gnt;
  assign sram_rden   = pop_gnt;
  assign sram_wrdata = push_data;
  assign pop_data    = sram_rddata;

  // Flags from the registered count.
  assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_count == CNT_W'(0));
  assign fifo_afull  = (fifo_count >= CNT_W'(AFULL_TH));
  assign fifo_aempty = (fifo_count <= CNT_W'(AEMPTY_TH));

  // Pointers, occupancy and read strobe. Grants are exclusive, so count moves by at most 1.
  always_ff @(posedge fifo_clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pop_valid  <= 1'b0;
      sram_rstb  <= 1'b0;
    end else begin
      if (push_gnt) begin
        wr_ptr     <= wr_ptr + FIFO_PTR'(1);
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop_gnt) begin
        rd_ptr     <= rd_ptr + FIFO_PTR'(1);
        fifo_count <= fifo_count - CNT_W'(1);
      end
      pop_valid <= pop_gnt;
      sram_rstb <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a small registered-read SRAM model.
module tb_sync_fifo_ctrl;

  logic       fifo_clk = 1'b0;
  logic       fifo_rst;
  logic       push_req;
  logic [7:0] push_data;
  logic       push_ack;
  logic       pop_req;
  logic       pop_ack;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_afull;
  logic       fifo_aempty;
  logic [4:0] fifo_count;
  logic [7:0] sram_wrdata;
  logic [7:0] sram_rddata;
  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
  logic       sram_wren;
  logic       sram_rden;
  logic       sram_rstb;

  logic [7:0] mem [16];
  int checks   = 0;
  int failures = 0;

  always #5 fifo_clk = ~fifo_clk;

  sync_fifo_ctrl dut (
    .fifo_clk    (fifo_clk),
    .fifo_rst    (fifo_rst),
    .push_req    (push_req),
    .push_data   (push_data),
    .push_ack    (push_ack),
    .pop_req     (pop_req),
    .pop_ack     (pop_ack),
    .pop_data    (pop_data),
    .pop_valid   (pop_valid),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_afull  (fifo_afull),
    .fifo_aempty (fifo_aempty),
    .fifo_count  (fifo_count),
    .sram_wrdata (sram_wrdata),
    .sram_rddata (sram_rddata),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .sram_wren   (sram_wren),
    .sram_rden   (sram_rden),
    .sram_rstb   (sram_rstb)
  );

  // SRAM model: write at the edge, registered read data.
  always @(posedge fifo_clk) begin
    if (sram_wren) mem[wr_ptr] <= sram_wrdata;
    if (sram_rden) sram_rddata <= mem[rd_ptr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge fifo_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo_rst  = 1'b1;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    push_data = 8'h00;
    tick; tick;
    chk("rst_count",  fifo_count, 0);
    chk("rst_empty",  fifo_empty, 1);
    chk("rst_aempty", fifo_aempty, 1);
    chk("rst_full",   fifo_full, 0);
    chk("rst_afull",  fifo_afull, 0);
    chk("rst_rstb",   sram_rstb, 0);
    chk("rst_valid",  pop_valid, 0);
    chk("rst_wrptr",  wr_ptr, 0);
    fifo_rst = 1'b0; #1;
    chk("rstb_hold", sram_rstb, 0);
    tick;
    chk("rstb_rise", sram_rstb, 1);

    // Fill 0x00..0x0F back to back.
    for (int i = 0; i < 16; i++) begin
      push_req = 1'b1; push_data = 8'(i); #1;
      chk("fill_ack",   push_ack, 1);
      chk("fill_cnt",   fifo_count, i);
      chk("fill_wrptr", wr_ptr, i);
      chk("fill_afull", fifo_afull, (i >= 12));
      chk("fill_empty", fifo_empty, (i == 0));
      tick;
    end
    // 17th push held while full.
    push_data = 8'h10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("full_ack",  push_ack, 0);
      chk("full_wren", sram_wren, 0);
      chk("full_cnt",  fifo_count, 16);
      chk("full_flag", fifo_full, 1);
      tick;
    end
    push_req = 1'b0;

    // Drain 16, data in order one cycle after each ack.
    for (int i = 0; i < 16; i++) begin
      pop_req = 1'b1; #1;
      chk("drain_ack",    pop_ack, 1);
      chk("drain_cnt",    fifo_count, 16 - i);
      chk("drain_aempty", fifo_aempty, ((16 - i) <= 4));
      chk("drain_full",   fifo_full, (i == 0));
      chk("drain_valid",  pop_valid, (i > 0));
      if (i > 0) chk("drain_data", pop_data, i - 1);
      tick;
    end
    #1;
    chk("drain_last_valid", pop_valid, 1);
    chk("drain_last_data",  pop_data, 8'h0F);
    chk("empty_pop_ack",    pop_ack, 0);
    chk("empty_flag",       fifo_empty, 1);
    chk("empty_cnt",        fifo_count, 0);
    tick;
    chk("empty_valid_drop", pop_valid, 0);
    chk("empty_pop_ack2",   pop_ack, 0);
    pop_req = 1'b0;

    // Preload 4, then contend for 8 cycles.
    for (int i = 0; i < 4; i++) begin
      push_req = 1'b1; push_data = 8'(8'h10 + i);
      tick;
    end
    for (int k = 0; k < 8; k++) begin
      push_req = 1'b1; pop_req = 1'b1; push_data = 8'(8'h20 + k / 2); #1;
      chk("arb_push", push_ack, (k % 2 == 0));
      chk("arb_pop",  pop_ack, (k % 2 == 1));
      chk("arb_excl", sram_wren & sram_rden, 0);
      chk("arb_cnt",  fifo_count, 4 + k % 2);
      if (k % 2 == 0 && k > 0) chk("arb_data", pop_data, 8'h10 + k / 2 - 1);
      tick;
    end
    push_req = 1'b0; pop_req = 1'b0; #1;
    chk("arb_end_cnt",  fifo_count, 4);
    chk("arb_end_data", pop_data, 8'h13);
    tick;
    for (int i = 0; i < 4; i++) begin
      pop_req = 1'b1; #1;
      chk("arb_drain_ack", pop_ack, 1);
      if (i > 0) chk("arb_drain_data", pop_data, 8'h20 + i - 1);
      tick;
    end
    pop_req = 1'b0; #1;
    chk("arb_drain_last", pop_data, 8'h23);
    chk("arb_drain_empty", fifo_empty, 1);
    tick;

    // Stream 40 items at occupancy <= 1; pointers start at 8 and wrap.
    for (int n = 0; n < 40; n++) begin
      push_req = 1'b1; pop_req = 1'b0; push_data = 8'(8'h40 + n); #1;
      chk("strm_push",  push_ack, 1);
      chk("strm_wrptr", wr_ptr, (8 + n) % 16);
      if (n > 0) begin
        chk("strm_valid", pop_valid, 1);
        chk("strm_data",  pop_data, 8'h40 + n - 1);
      end
      tick;
      push_req = 1'b0; pop_req = 1'b1; #1;
      chk("strm_pop",   pop_ack, 1);
      chk("strm_rdptr", rd_ptr, (8 + n) % 16);
      tick;
    end
    pop_req = 1'b0; #1;
    chk("strm_last_valid", pop_valid, 1);
    chk("strm_last_data",  pop_data, 8'h67);
    chk("strm_end_cnt",    fifo_count, 0);
    chk("strm_end_wrptr",  wr_ptr, 0);
    tick;

    // Reset mid-stream at count 7 with pop_valid high.
    for (int i = 0; i < 8; i++) begin
      push_req = 1'b1; push_data = 8'(8'h70 + i);
      tick;
    end
    push_req = 1'b0; pop_req = 1'b1;
    tick;
    chk("pre_rst_cnt",   fifo_count, 7);
    chk("pre_rst_valid", pop_valid, 1);
    push_req = 1'b1; pop_req = 1'b1; fifo_rst = 1'b1; #1;
    chk("mid_rst_cnt",    fifo_count, 0);
    chk("mid_rst_empty",  fifo_empty, 1);
    chk("mid_rst_aempty", fifo_aempty, 1);
    chk("mid_rst_full",   fifo_full, 0);
    chk("mid_rst_afull",  fifo_afull, 0);
    chk("mid_rst_pack",   push_ack, 0);
    chk("mid_rst_rack",   pop_ack, 0);
    chk("mid_rst_wren",   sram_wren, 0);
    chk("mid_rst_rden",   sram_rden, 0);
    chk("mid_rst_valid",  pop_valid, 0);
    chk("mid_rst_rstb",   sram_rstb, 0);
    chk("mid_rst_ptrs",   {wr_ptr, rd_ptr}, 0);
    tick;
    chk("mid_rst_rstb_edge", sram_rstb, 0);
    push_req = 1'b0; pop_req = 1'b0; fifo_rst = 1'b0; #1;
    chk("rel_rstb_hold", sram_rstb, 0);
    tick;
    chk("rel_rstb_rise", sram_rstb, 1);

    // Empty FIFO, push and pop raised together.
    push_req = 1'b1; pop_req = 1'b1; push_data = 8'hA5; #1;
    chk("a5_c0_push", push_ack, 1);
    chk("a5_c0_pop",  pop_ack, 0);
    tick;
    push_req = 1'b0; #1;
    chk("a5_c1_pop",  pop_ack, 1);
    chk("a5_c1_push", push_ack, 0);
    tick;
    pop_req = 1'b0; #1;
    chk("a5_c2_valid", pop_valid, 1);
    chk("a5_c2_data",  pop_data, 8'hA5);
    tick;
    chk("a5_c3_valid", pop_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
